ddot_arb: RTL
=============

Name: ddot_arb

Overview:
- Round-robin arbiter and scheduler that shares one ddot_fsmd (8-lane FP32 dot-product FSMD, `ready`-in / `valid`+`z`-out, accepts one operand set per cycle) between two requesters.
- Grants one requester per cycle and drives the registered operand set plus `ready` into ddot_fsmd.
- Records each issue's requester ID in an in-order tag FIFO and routes each `valid`/`z` result back to its owner.
- Sits between the stream front-ends and the ddot_fsmd instance.

Parameters:
- DEPTH, 8, maximum in-flight operand sets; must be a power of 2, ≥ ddot_fsmd latency + 1.
- LANES, 8, vector lanes per operand set; fixed to match ddot_fsmd.
- FP_W, 32, FP32 element width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 offers an operand set.
- req0_x  in  LANES*FP_W  packed x vector; lane i = bits [32i+31:32i].
- req0_y  in  LANES*FP_W  packed y vector, same packing.
- req0_gnt  out  1  combinational; set accepted this cycle.
- req1_valid, req1_x, req1_y, req1_gnt  same as requester 0.
- dd_ready  out  1  to ddot_fsmd `ready`.
- dd_x  out  LANES*FP_W  to ddot_fsmd x0..x7.
- dd_y  out  LANES*FP_W  to ddot_fsmd y0..y7.
- dd_valid  in  1  from ddot_fsmd `valid`.
- dd_z  in  FP_W  from ddot_fsmd `z`.
- rsp0_valid  out  1  result for requester 0.
- rsp0_z  out  FP_W  result value for requester 0.
- rsp1_valid, rsp1_z  out  same for requester 1.
- inflight  out  $clog2(DEPTH)+1  current in-flight count.
- err  out  1  sticky; `dd_valid` arrived with empty tag FIFO.

Behaviour:
- Reset (synchronous, active-high, `clk` posedge; overrides everything):
  - All outputs 0; `dd_x`/`dd_y` zero.
  - Tag FIFO emptied; `inflight` = 0; `err` cleared.
  - Round-robin pointer set so requester 0 wins the first tie.
  - Reset mid-operation discards in-flight tags; results arriving after reset deassertion with an empty FIFO set `err`.
- `can_issue` = (`inflight` < DEPTH).
- Arbitration (combinational):
  - Only one requester valid and `can_issue` → grant it.
  - Both valid and `can_issue` → grant the requester not granted last.
  - `can_issue` = 0 → no grant.
  - Exactly 0 or 1 `gnt` high per cycle.
- Issue stage (registered):
  - On grant, next cycle: `dd_ready` = 1, `dd_x`/`dd_y` hold the granted operands, and the requester ID is pushed to the tag FIFO.
  - No grant → `dd_ready` = 0; `dd_x`/`dd_y` hold their previous value.
  - Issue latency: `gnt` at cycle N → `dd_ready` at N+1.
  - Back-to-back grants give continuous `dd_ready`.
- Requester contract:
  - Requester holds `valid`/`x`/`y` stable until `gnt`.
  - It may drop `valid` without `gnt`; no penalty.
- Completion (registered):
  - On `dd_valid` with FIFO non-empty: pop head tag; next cycle assert `rspT_valid` for 1 cycle with `rspT_z` = `dd_z`.
  - The other `rsp*_valid` stays 0.
  - `rsp*_z` holds its last value when not valid.
  - Completion latency: `dd_valid` at cycle M → `rsp` at M+1.
  - `dd_valid` with FIFO empty: no response, no pop; `err` set and held until `rst`.
- Counter:
  - `inflight` +1 on push, −1 on pop.
  - Push and pop in the same cycle → unchanged.
  - Pop at `inflight` = DEPTH frees a slot; `can_issue` is evaluated on the registered count, so the new grant appears the following cycle.
- ddot_fsmd returns results in issue order; in-order tags rely on this. No response backpressure: requesters must sink `rsp` every cycle.
- No arithmetic inside the block; FP values pass through bit-exact.

Decomposition:
- Package ddot_pkg: LANES, FP_W, vector width constant (LANES*FP_W), tag type (1-bit requester ID), and a helper function to extract lane i from a packed vector.
- One sub-module, ddot_tag_fifo: synchronous FIFO, DEPTH entries × tag width.
  - Ports: push, pop, din, dout, empty, full, count.
  - Wrap-around pointers with an extra MSB for full/empty.
  - Simultaneous push+pop allowed when full or empty-with-push.
- Arbiter, issue registers and response routing live in ddot_arb.

Test Plan:
- Single request: after reset, req0 offers all lanes x = y = 0x3F800000 → `req0_gnt` same cycle, `dd_ready` next cycle; ddot result 0x41000000 (8.0) → `rsp0_valid` 1 cycle later with `rsp0_z` = 0x41000000; `rsp1_valid` stays 0.
- Contention: req0 (all 0x3F800000) and req1 (all 0x40000000) valid continuously for 4 cycles → grants alternate 0,1,0,1; responses 0x41000000 on rsp0 and 0x42000000 (32.0) on rsp1, in issue order.
- Full condition: DEPTH = 4, ddot stubbed to delay results by 10 cycles, req0 valid continuously → exactly 4 grants, then `gnt` low and `inflight` = 4; the first result pop re-enables the grant the cycle after the count drops.
- Simultaneous issue and completion: grant and `dd_valid` in the same cycle → `inflight` unchanged, tag order preserved, correct routing.
- Spurious result: `dd_valid` pulse with `inflight` = 0 → no `rsp*_valid`, `err` = 1 and held; `rst` clears it.
- Reset mid-operation: `rst` asserted with 3 in flight → next cycle all outputs 0, `inflight` = 0; a first grant after release goes to req0 when both requesters are valid.

Source files
------------

// File: rtl/ddot_pkg.sv
// Shared constants and types for the ddot_fsmd arbiter: vector geometry,
// requester tag type and a lane-extraction helper.
package ddot_pkg;

    localparam int LANES = 8;
    localparam int FP_W  = 32;
    localparam int VEC_W = LANES * FP_W;
    localparam int TAG_W = 1;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    function automatic logic [FP_W-1:0] get_lane(input logic [VEC_W-1:0] v,
                                                 input int unsigned     idx);
        return v[idx*FP_W +: FP_W];
    endfunction

endpackage

// File: rtl/ddot_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per operand set in flight.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module ddot_tag_fifo
    import ddot_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  req_id_t                din,
    output req_id_t                dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    req_id_t     mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count   = wr_q - rd_q;
    assign dout    = mem_q[rd_q[AW-1:0]];
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ddot_arb.sv
// Round-robin arbiter sharing one ddot_fsmd between two requesters; issues
// registered operand sets and routes in-order results back by tag.
module ddot_arb
    import ddot_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_valid,
    input  logic [VEC_W-1:0]       req0_x,
    input  logic [VEC_W-1:0]       req0_y,
    output logic                   req0_gnt,
    input  logic                   req1_valid,
    input  logic [VEC_W-1:0]       req1_x,
    input  logic [VEC_W-1:0]       req1_y,
    output logic                   req1_gnt,
    output logic                   dd_ready,
    output logic [VEC_W-1:0]       dd_x,
    output logic [VEC_W-1:0]       dd_y,
    input  logic                   dd_valid,
    input  logic [FP_W-1:0]        dd_z,
    output logic                   rsp0_valid,
    output logic [FP_W-1:0]        rsp0_z,
    output logic                   rsp1_valid,
    output logic [FP_W-1:0]        rsp1_z,
    output logic [$clog2(DEPTH):0] inflight,
    output logic                   err
);

    req_id_t          last_q, last_d;
    logic             dd_ready_q, dd_ready_d;
    logic [VEC_W-1:0] dd_x_q, dd_x_d;
    logic [VEC_W-1:0] dd_y_q, dd_y_d;
    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [FP_W-1:0]  rsp0_z_q, rsp0_z_d;
    logic [FP_W-1:0]  rsp1_z_q, rsp1_z_d;
    logic             err_q, err_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             any_gnt;
    logic             pop;
    req_id_t          gnt_id;
    req_id_t          head_id;

    // Handshake: a set transfers in any cycle with reqN_valid && reqN_gnt; the
    // requester holds x/y while valid && !gnt and may withdraw valid freely.
    // Full FIFO is exactly inflight == DEPTH, so !full is the issue permission.
    always_comb begin
        req0_gnt = 1'b0;
        req1_gnt = 1'b0;
        if (!fifo_full) begin
            if (req0_valid && req1_valid) begin
                if (last_q == REQ0) req1_gnt = 1'b1;
                else                req0_gnt = 1'b1;
            end else begin
                req0_gnt = req0_valid;
                req1_gnt = req1_valid;
            end
        end
    end

    assign any_gnt = req0_gnt | req1_gnt;
    assign gnt_id  = req1_gnt ? REQ1 : REQ0;
    assign pop     = dd_valid && !fifo_empty;

    always_comb begin
        last_d       = any_gnt ? gnt_id : last_q;
        dd_ready_d   = any_gnt;
        dd_x_d       = dd_x_q;
        dd_y_d       = dd_y_q;
        if (req0_gnt) begin
            dd_x_d = req0_x;
            dd_y_d = req0_y;
        end else if (req1_gnt) begin
            dd_x_d = req1_x;
            dd_y_d = req1_y;
        end
        rsp0_valid_d = pop && (head_id == REQ0);
        rsp1_valid_d = pop && (head_id == REQ1);
        rsp0_z_d     = rsp0_valid_d ? dd_z : rsp0_z_q;
        rsp1_z_d     = rsp1_valid_d ? dd_z : rsp1_z_q;
        err_d        = err_q | (dd_valid && fifo_empty);
    end

    // REQ1 as "last granted" makes requester 0 win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q       <= REQ1;
            dd_ready_q   <= 1'b0;
            dd_x_q       <= '0;
            dd_y_q       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_z_q     <= '0;
            rsp1_z_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            last_q       <= last_d;
            dd_ready_q   <= dd_ready_d;
            dd_x_q       <= dd_x_d;
            dd_y_q       <= dd_y_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_z_q     <= rsp0_z_d;
            rsp1_z_q     <= rsp1_z_d;
            err_q        <= err_d;
        end
    end

    ddot_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (any_gnt),
        .pop   (pop),
        .din   (gnt_id),
        .dout  (head_id),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (inflight)
    );

    assign dd_ready   = dd_ready_q;
    assign dd_x       = dd_x_q;
    assign dd_y       = dd_y_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_z     = rsp0_z_q;
    assign rsp1_z     = rsp1_z_q;
    assign err        = err_q;

endmodule
